// File: rtl/cond_flags_unit.sv
// Conditional-execution stage behind the ULA: evaluates ARM condition codes against the
// registered NZCV flags, gates PC/register/memory writes, and registers the accepted result.
module cond_flags_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             CondEx,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic [WIDTH-1:0] Result,
   output logic             valid_out,
   output logic [CNT_W-1:0] squash_cnt
);

   logic             cond_pass;
   logic [3:0]       flags_p1;
   logic [WIDTH-1:0] result_p1;
   logic             vld_p1;
   logic [CNT_W-1:0] squash_p1;

   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, p;
      {n, z, cy, v} = f;
      p = 1'b0;
      case (c)
         4'b0000: p = z;
         4'b0001: p = !z;
         4'b0010: p = cy;
         4'b0011: p = !cy;
         4'b0100: p = n;
         4'b0101: p = !n;
         4'b0110: p = v;
         4'b0111: p = !v;
         4'b1000: p = cy && !z;
         4'b1001: p = !cy || z;
         4'b1010: p = (n == v);
         4'b1011: p = (n != v);
         4'b1100: p = !z && (n == v);
         4'b1101: p = z || (n != v);
         4'b1110: p = 1'b1;
         4'b1111: p = 1'b0;
      endcase
      return p;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   // Stage p0: condition evaluated against the flags already registered, never ALUFlags
   always_comb begin
      cond_pass = cond_eval(Cond, flags_p1);
      CondEx    = valid_in & cond_pass;
      PCSrc     = PCS & CondEx;
      MemWrite  = MemW & CondEx;
      RegWrite  = RegW & CondEx & !NoWrite;
   end

   // Stage p1: architectural flags, writeback result and squash count
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_p1  <= 4'b0000;
         result_p1 <= '0;
         vld_p1    <= 1'b0;
         squash_p1 <= '0;
      end else begin
         if (CondEx && FlagW[1]) flags_p1[3:2] <= ALUFlags[3:2];
         if (CondEx && FlagW[0]) flags_p1[1:0] <= ALUFlags[1:0];
         if (RegWrite) begin
            result_p1 <= ALUResult;
            vld_p1    <= 1'b1;
         end else begin
            vld_p1    <= 1'b0;
         end
         if (valid_in && !cond_pass) squash_p1 <= sat_inc(squash_p1);
      end
   end

   assign Flags      = flags_p1;
   assign Result     = result_p1;
   assign valid_out  = vld_p1;
   assign squash_cnt = squash_p1;

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Conditional-execution and flag-state stage directly downstream of the ULA.
- Holds the architectural NZCV flag register, which is loaded from the ULA Flags output.
- Evaluates the 4-bit ARM condition field of each instruction against the registered flags, and gates register, memory and PC writes accordingly.
- Registers the accepted ULA result for writeback and counts squashed (condition-failed) instructions.

Parameters:
- WIDTH, 32, data width of the ULA result path.
- CNT_W, 16, width of the squashed-instruction counter (saturating).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  an instruction with valid ULA outputs is present this cycle.
- Cond  input  4  ARM condition field, instr[31:28].
- ALUFlags  input  4  ULA Flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- ALUResult  input  WIDTH  ULA y output.
- FlagW  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  instruction writes PC.
- RegW  input  1  instruction writes the register file.
- MemW  input  1  instruction writes memory.
- NoWrite  input  1  compare-type op (CMP/CMN/TST): suppresses RegWrite.
- CondEx  output  1  condition passed (combinational).
- PCSrc  output  1  PCS gated (combinational).
- RegWrite  output  1  RegW gated (combinational).
- MemWrite  output  1  MemW gated (combinational).
- Flags  output  4  registered NZCV.
- Result  output  WIDTH  registered accepted ULA result.
- valid_out  output  1  Result holds a new value this cycle.
- squash_cnt  output  CNT_W  count of valid_in instructions whose condition failed.

Behaviour:
- Reset (synchronous, on posedge clk while reset=1):
  - Flags=0, Result=0, valid_out=0, squash_cnt=0.
  - While reset is held, the combinational outputs still follow the inputs evaluated against Flags=0.
- Condition decode, using the current registered Flags (N,Z,C,V), never the incoming ALUFlags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (never).
- Gating: CondEx = valid_in & cond_pass.
  - PCSrc = PCS & CondEx.
  - MemWrite = MemW & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
- Flag update at posedge:
  - If CondEx & FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If CondEx & FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Either half may be updated independently; the other half holds.
  - A failed condition never updates flags.
- Latency: flags written in cycle n are visible to the condition evaluation of cycle n+1 (back-to-back CMP then BEQ works with zero bubbles).
- Result register:
  - At posedge, if RegWrite=1: Result <= ALUResult and valid_out <= 1.
  - Otherwise valid_out <= 0 and Result holds.
  - valid_out is therefore a single-cycle pulse per accepted write, one cycle after acceptance.
- Squash counter:
  - At posedge, if valid_in & !cond_pass, squash_cnt increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
- valid_in=0:
  - All gated outputs are 0.
  - Flags, squash_cnt and Result hold; valid_out goes to 0 next cycle.
- Reset asserted mid-stream has priority over every update in the same cycle: flags clear and any pending valid_out is dropped.

Test Plan:
- Reset, then valid_in=1, Cond=1110, RegW=1, FlagW=11, ALUResult=0000_0005, ALUFlags=0000 -> same cycle: RegWrite=1, CondEx=1. Next cycle: Result=0000_0005, valid_out=1, Flags=0000.
- CMP-style: FlagW=11, NoWrite=1, RegW=1, ALUFlags=0100 (Z), Cond=1110. Next cycle: Cond=0000 (EQ), PCS=1 -> first cycle RegWrite=0; second cycle PCSrc=1, Flags=0100. Repeat with Cond=0001 -> PCSrc=0 and squash_cnt increments by 1.
- Partial write: Flags=1111, then FlagW=10 with ALUFlags=0000 -> Flags=0011. Then FlagW=01 with ALUFlags=0000 -> Flags=0000.
- Signed compares: Flags=1000 (N=1, V=0) -> GE fails, LT passes, GT fails, LE passes. Flags=1001 -> GE passes, GT passes. Flags=0010 -> HI passes; Flags=0110 -> LS passes.
- Failed condition: Cond=1111, FlagW=11, MemW=1, ALUFlags=1111 -> MemWrite=0, Flags unchanged, squash_cnt +1. With CNT_W=2, drive 5 failures -> squash_cnt stays at 3.
- Reset mid-operation: RegW accepted at cycle n and reset=1 at cycle n+1 -> at cycle n+2 valid_out=0, Flags=0000, Result=0, squash_cnt=0.
